// File: rtl/regfile_wr_arbiter_pkg.sv
// regfile_wr_arbiter_pkg
//   Shared defaults for the register-file write path: data/address widths,
//   register count, and the requester indices used by the arbiter, the
//   register file and the hazard unit.
//   No ports (package).
package regfile_wr_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREG_DEF   = 32;

  // Requester identities; also the encoding of the arbiter's last-grant state.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_wr_arbiter_slot.sv
// rf_wr_slot
//   One-entry holding register for a single writeback requester. The slot
//   accepts a new request whenever it is empty or is being drained in the same
//   cycle, so a continuously valid requester can sustain one write per cycle.
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset (0 = empty the slot)
//   valid_i  in   requester has a write this cycle
//   addr_i   in   destination register of the offered write
//   data_i   in   data of the offered write
//   ready_o  out  slot accepts the offered write at the next edge
//   drain_i  in   arbiter grants this slot this cycle
//   valid_o  out  slot holds a write
//   addr_o   out  held destination register
//   data_o   out  held write data
module rf_wr_slot
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  input  logic              drain_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              load;

  assign ready_o = ~valid_q | drain_i;
  assign load    = valid_i & ready_o;

  // Next-state: a load wins over a drain so a drained slot refills in place.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the register file's single write port between the ALU writeback
//   (req0) and the load / HI-LO writeback (req1). Each requester owns a
//   one-entry slot; one slot is granted per cycle into a registered write stage
//   that drives one-hot register enables plus shared write data. Writes to
//   register 0 are consumed but never enabled. pend_mask flags every register
//   with a write still in a slot or in the write stage.
// Ports
//   clk, reset                      clock, asynchronous active-low reset
//   reqK_valid/addr/data/ready      per-requester valid/ready write channel
//   rf_en                           one-hot register enables (registered)
//   rf_wdata                        shared register write data (registered)
//   pend_mask                       in-flight destination registers
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NREG      = NREG_DEF,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [NREG-1:0]   rf_en,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   pend_mask
);

  logic              s0_v, s1_v;
  logic [ADDR_W-1:0] s0_addr, s1_addr;
  logic [DATA_W-1:0] s0_data, s1_data;
  logic              gnt0, gnt1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  req_id_e           last_grant_q, last_grant_d;
  logic [NREG-1:0]   rf_en_q, rf_en_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  // Address decode with $zero suppressed: register 0 never gets an enable
  // and never shows as pending.
  function automatic logic [NREG-1:0] decode(input logic [ADDR_W-1:0] a,
                                             input logic              v);
    logic [NREG-1:0] dec;
    dec = '0;
    if (v && (a != '0)) begin
      dec[a] = 1'b1;
    end else begin
      dec = '0;
    end
    return dec;
  endfunction

  rf_wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
    .clk     (clk),
    .reset   (reset),
    .valid_i (req0_valid),
    .addr_i  (req0_addr),
    .data_i  (req0_data),
    .ready_o (req0_ready),
    .drain_i (gnt0),
    .valid_o (s0_v),
    .addr_o  (s0_addr),
    .data_o  (s0_data)
  );

  rf_wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
    .clk     (clk),
    .reset   (reset),
    .valid_i (req1_valid),
    .addr_i  (req1_addr),
    .data_i  (req1_data),
    .ready_o (req1_ready),
    .drain_i (gnt1),
    .valid_o (s1_v),
    .addr_o  (s1_addr),
    .data_o  (s1_data)
  );

  // Arbitration over slot valids only; on contention round-robin grants the
  // slot that did not win last, fixed priority always grants slot 0.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (s0_v && s1_v) begin
      if ((PRIO_MODE == 1) || (last_grant_q == REQ_MEM)) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else if (s0_v) begin
      gnt0 = 1'b1;
    end else if (s1_v) begin
      gnt1 = 1'b1;
    end else begin
      gnt0 = 1'b0;
    end
  end

  assign sel_addr = gnt1 ? s1_addr : s0_addr;
  assign sel_data = gnt1 ? s1_data : s0_data;

  // Write-stage next state: enables pulse for one cycle per grant, data holds
  // between grants so the register d-inputs do not toggle needlessly.
  always_comb begin
    rf_en_d      = '0;
    rf_wdata_d   = rf_wdata_q;
    last_grant_d = last_grant_q;
    if (gnt0 || gnt1) begin
      rf_en_d      = decode(sel_addr, 1'b1);
      rf_wdata_d   = sel_data;
      last_grant_d = gnt1 ? REQ_MEM : REQ_ALU;
    end else begin
      rf_en_d = '0;
    end
  end

  // Write-stage and arbiter-history registers; after reset req0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_en_q      <= '0;
      rf_wdata_q   <= '0;
      last_grant_q <= REQ_MEM;
    end else begin
      rf_en_q      <= rf_en_d;
      rf_wdata_q   <= rf_wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rf_en     = rf_en_q;
  assign rf_wdata  = rf_wdata_q;
  assign pend_mask = decode(s0_addr, s0_v) | decode(s1_addr, s1_v) | rf_en_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic a_v0, a_v1, a_r0, a_r1;
  logic [AW-1:0] a_a0, a_a1;
  logic [DW-1:0] a_d0, a_d1, a_wd;
  logic [NR-1:0] a_en, a_pend;

  logic b_v0, b_v1, b_r0, b_r1;
  logic [AW-1:0] b_a0, b_a1;
  logic [DW-1:0] b_d0, b_d1, b_wd;
  logic [NR-1:0] b_en, b_pend;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [NR-1:0] en;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR), .PRIO_MODE(0)) dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(a_v0), .req0_addr(a_a0), .req0_data(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_addr(a_a1), .req1_data(a_d1), .req1_ready(a_r1),
    .rf_en(a_en), .rf_wdata(a_wd), .pend_mask(a_pend)
  );

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR), .PRIO_MODE(1)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_v0), .req0_addr(b_a0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_addr(b_a1), .req1_data(b_d1), .req1_ready(b_r1),
    .rf_en(b_en), .rf_wdata(b_wd), .pend_mask(b_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NR-1:0] en, input logic [DW-1:0] data);
    exp_t e;
    e.en = en;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Monitor: every write-stage pulse of dut_a is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      check("a_onehot0", 64'($onehot0(a_en)), 64'd1);
      check("a_pend_bit0", 64'(a_pend[0]), 64'd0);
      if (a_en != '0) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_write", 64'(a_en), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_en", 64'(a_en), 64'(e.en));
          check("sb_data", 64'(a_wd), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    a_v0 = 1'b0; a_v1 = 1'b0; a_a0 = '0; a_a1 = '0; a_d0 = '0; a_d1 = '0;
    b_v0 = 1'b0; b_v1 = 1'b0; b_a0 = '0; b_a1 = '0; b_d0 = '0; b_d1 = '0;

    // Reset state
    #12;
    check("rst_en", 64'(a_en), 64'd0);
    check("rst_wdata", 64'(a_wd), 64'd0);
    check("rst_pend", 64'(a_pend), 64'd0);
    check("rst_ready0", 64'(a_r0), 64'd1);
    check("rst_ready1", 64'(a_r1), 64'd1);
    check("rst_b_en", 64'(b_en), 64'd0);
    tick();
    reset = 1'b1;

    // Round-robin stream: both valid every cycle, addr 3 / 7
    a_v0 = 1'b1; a_a0 = 5'd3; a_d0 = 32'hA0A0_0003;
    a_v1 = 1'b1; a_a1 = 5'd7; a_d1 = 32'hB1B1_0007;
    push(32'h08, 32'hA0A0_0003);
    push(32'h80, 32'hB1B1_0007);
    push(32'h08, 32'hA0A0_0003);
    push(32'h80, 32'hB1B1_0007);
    push(32'h08, 32'hA0A0_0003);
    for (int j = 0; j <= 6; j++) begin
      tick();
      if (j == 0) begin
        check("rr_first_ready0", 64'(a_r0), 64'd1);
        check("rr_first_ready1", 64'(a_r1), 64'd0);
        check("rr_pend", 64'(a_pend), 64'h88);
      end else if (j == 1) begin
        check("rr_first_grant", 64'(a_en), 64'h08);
      end else if (j == 2) begin
        check("rr_second_grant", 64'(a_en), 64'h80);
      end
    end

    // Mid-stream reset with both slots full
    reset = 1'b0;
    #1;
    check("mid_rst_en", 64'(a_en), 64'd0);
    check("mid_rst_pend", 64'(a_pend), 64'd0);
    check("mid_rst_ready0", 64'(a_r0), 64'd1);
    check("mid_rst_ready1", 64'(a_r1), 64'd1);
    check("mid_rst_wdata", 64'(a_wd), 64'd0);
    a_v0 = 1'b0; a_v1 = 1'b0;
    tick();
    reset = 1'b1;

    // Single req0 write: addr 5, DEADBEEF, two edges to the enable pulse
    a_v0 = 1'b1; a_a0 = 5'd5; a_d0 = 32'hDEAD_BEEF;
    push(32'h20, 32'hDEAD_BEEF);
    tick();
    a_v0 = 1'b0;
    check("t2_pend_slot", 64'(a_pend), 64'h20);
    check("t2_en_early", 64'(a_en), 64'd0);
    tick();
    check("t2_en", 64'(a_en), 64'h20);
    check("t2_wdata", 64'(a_wd), 64'hDEAD_BEEF);
    check("t2_pend_stage", 64'(a_pend), 64'h20);
    tick();
    check("t2_pulse_end", 64'(a_en), 64'd0);
    check("t2_wdata_hold", 64'(a_wd), 64'hDEAD_BEEF);
    check("t2_pend_clear", 64'(a_pend), 64'd0);

    // req1 write to $zero: consumed, never enabled
    a_v1 = 1'b1; a_a1 = 5'd0; a_d1 = 32'd1;
    check("t4_ready1", 64'(a_r1), 64'd1);
    tick();
    a_v1 = 1'b0;
    check("t4_pend", 64'(a_pend), 64'd0);
    tick();
    check("t4_en", 64'(a_en), 64'd0);
    check("t4_wdata", 64'(a_wd), 64'd1);
    check("t4_slot_free", 64'(a_r1), 64'd1);
    tick();

    // Same address from both requesters: 11 then 22
    a_v0 = 1'b1; a_a0 = 5'd9; a_d0 = 32'd11;
    a_v1 = 1'b1; a_a1 = 5'd9; a_d1 = 32'd22;
    push(32'h200, 32'd11);
    push(32'h200, 32'd22);
    tick();
    a_v0 = 1'b0; a_v1 = 1'b0;
    check("t5_pend_a", 64'(a_pend), 64'h200);
    tick();
    check("t5_first", 64'(a_wd), 64'd11);
    check("t5_pend_b", 64'(a_pend), 64'h200);
    tick();
    check("t5_second", 64'(a_wd), 64'd22);
    check("t5_pend_c", 64'(a_pend), 64'h200);
    tick();
    check("t5_done_en", 64'(a_en), 64'd0);
    check("t5_done_pend", 64'(a_pend), 64'd0);
    check("t5_final", 64'(a_wd), 64'd22);

    // Fixed priority: req0 continuous, req1 waits until req0 drops
    b_v0 = 1'b1; b_a0 = 5'd1; b_d0 = 32'h100;
    b_v1 = 1'b1; b_a1 = 5'd2; b_d1 = 32'h55;
    tick();
    b_v1 = 1'b0;
    b_d0 = 32'h101;
    check("t6_ready1_full", 64'(b_r1), 64'd0);
    check("t6_pend", 64'(b_pend), 64'h06);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t6_en_req0", 64'(b_en), 64'h02);
      check("t6_wdata_req0", 64'(b_wd), 64'(32'h100 + i - 1));
      check("t6_ready1_wait", 64'(b_r1), 64'd0);
      b_d0 = 32'h100 + i + 1;
    end
    b_v0 = 1'b0;
    tick();
    check("t6_last_req0", 64'(b_wd), 64'h104);
    check("t6_req1_granted", 64'(b_r1), 64'd1);
    tick();
    check("t6_en_req1", 64'(b_en), 64'h04);
    check("t6_wdata_req1", 64'(b_wd), 64'h55);
    tick();
    check("t6_idle", 64'(b_en), 64'd0);

    tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
